// File: rtl/wragent_arbiter.sv
// Round-robin arbiter merging NB_WRAGENT write agents onto one registered RAM write port.
// Define WRAGENT_ARBITER_BURST_EN to let an agent keep the port for up to MAX_BURST beats.
module wragent_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_WRAGENT   = 4,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  parameter int MAX_BURST    = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  output logic [NB_WRAGENT-1:0]            wrrdy,
  output logic                             mem_wren,
  output logic [ADDR_WIDTH-1:0]            mem_wraddr,
  output logic [DATA_WIDTH-1:0]            mem_wrdata,
  output logic [SELECT_WIDTH-1:0]          mem_wrsel,
  output logic                             dbg_hold
);

`ifdef WRAGENT_ARBITER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam int                      CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX   = CNT_WIDTH'(MAX_BURST);
  localparam logic [SELECT_WIDTH-1:0] LAST_IDX  = SELECT_WIDTH'(NB_WRAGENT - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state;
  logic [SELECT_WIDTH-1:0] ptr;
  logic [SELECT_WIDTH-1:0] owner;
  logic [CNT_WIDTH-1:0]    cnt;

  logic                    gnt_valid;
  logic                    gnt_keep;
  logic [SELECT_WIDTH-1:0] gnt_idx;
  logic [SELECT_WIDTH-1:0] cand;

  function automatic logic [SELECT_WIDTH-1:0] next_idx(input logic [SELECT_WIDTH-1:0] k);
    return (k == LAST_IDX) ? '0 : k + 1'b1;
  endfunction

  // Handshake: agent i offers a beat with wren[i]; the beat transfers in the cycle
  // wren[i] && wrrdy[i]; wrrdy is one-hot or zero and only ever follows a high wren.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_keep  = 1'b0;
    gnt_idx   = '0;
    cand      = ptr;
    if (state == HOLD && wren[owner] && cnt < CNT_MAX) begin
      gnt_valid = 1'b1;
      gnt_keep  = 1'b1;
      gnt_idx   = owner;
    end else begin
      // ptr already points past the owner, so a released burst searches the others first
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (!gnt_valid && wren[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
        cand = next_idx(cand);
      end
    end
  end

  always_comb begin
    wrrdy = '0;
    if (aresetn && gnt_valid) wrrdy[gnt_idx] = 1'b1;
  end

  assign dbg_hold = (state == HOLD);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      mem_wren   <= 1'b0;
      mem_wraddr <= '0;
      mem_wrdata <= '0;
      mem_wrsel  <= '0;
    end else begin
      mem_wren <= gnt_valid;
      if (gnt_valid) begin
        mem_wraddr <= wraddr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wrdata <= wrdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        mem_wrsel  <= gnt_idx;
      end
      if (gnt_keep) begin
        cnt <= cnt + 1'b1;
      end else if (gnt_valid) begin
        ptr <= next_idx(gnt_idx);
        if (BURST_EN && MAX_BURST > 1) begin
          state <= HOLD;
          owner <= gnt_idx;
          cnt   <= CNT_WIDTH'(1);
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wragent_arbiter.sv
// Bench for wragent_arbiter: per-cycle round-robin model plus directed literal checks.
module tb_wragent_arbiter;
  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SW   = 2;
  localparam int MAXB = 4;
  localparam int EW   = 1 + SW + AW + DW;
`ifdef WRAGENT_ARBITER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic [N-1:0]  wren    = '0;
  logic [N*AW-1:0] wraddr = '0;
  logic [N*DW-1:0] wrdata = '0;
  logic [N-1:0]  wrrdy;
  logic          mem_wren;
  logic [AW-1:0] mem_wraddr;
  logic [DW-1:0] mem_wrdata;
  logic [SW-1:0] mem_wrsel;
  logic          dbg_hold;

  wragent_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(N), .SELECT_WIDTH(SW), .MAX_BURST(MAXB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .wrrdy(wrrdy), .mem_wren(mem_wren), .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata),
    .mem_wrsel(mem_wrsel), .dbg_hold(dbg_hold)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int m_owner = -1;
  int m_beats = 0;
  int m_next  = 0;
  int cyc     = 0;
  bit fix2    = 1'b0;

  logic [N-1:0]  r_rdy;
  logic          r_w;
  logic [SW-1:0] r_sel;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model of the arbitration rules, checked every falling edge
  always @(negedge aclk) begin
    logic [EW-1:0] e;
    logic [N-1:0]  erdy;
    int g;
    int start;
    if (!aresetn) begin
      chk("rst_wrrdy", 64'(wrrdy), 64'(0));
      chk("rst_mem_wren", 64'(mem_wren), 64'(0));
      chk("rst_mem_wraddr", 64'(mem_wraddr), 64'(0));
      chk("rst_mem_wrdata", 64'(mem_wrdata), 64'(0));
      chk("rst_mem_wrsel", 64'(mem_wrsel), 64'(0));
      exp_q.delete();
      exp_q.push_back('0);
      m_owner = -1;
      m_beats = 0;
      m_next  = 0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("mem_wren", 64'(mem_wren), 64'(e[EW-1]));
        if (e[EW-1]) begin
          chk("mem_wrsel", 64'(mem_wrsel), 64'(e[EW-2 -: SW]));
          chk("mem_wraddr", 64'(mem_wraddr), 64'(e[DW +: AW]));
          chk("mem_wrdata", 64'(mem_wrdata), 64'(e[DW-1:0]));
        end
      end
      chk("dbg_hold", 64'(dbg_hold), 64'(m_owner >= 0));
      g = -1;
      if (BURST && m_owner >= 0 && wren[m_owner] && m_beats < MAXB) begin
        g = m_owner;
        m_beats++;
      end else begin
        start = (m_owner >= 0) ? (m_owner + 1) % N : m_next;
        for (int i = 0; i < N; i++)
          if (g < 0 && wren[(start + i) % N]) g = (start + i) % N;
        if (g >= 0) begin
          m_next = (g + 1) % N;
          if (BURST && MAXB > 1) begin m_owner = g; m_beats = 1; end
          else begin m_owner = -1; m_beats = 0; end
        end else begin
          if (m_owner >= 0) m_next = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end
      end
      erdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("wrrdy", 64'(wrrdy), 64'(erdy));
      if (g >= 0) exp_q.push_back({1'b1, SW'(g), wraddr[g*AW +: AW], wrdata[g*DW +: DW]});
      else        exp_q.push_back('0);
    end
  end

  // driver: new request vector each cycle, fresh addr/data per agent
  task automatic step(input logic [N-1:0] w);
    @(posedge aclk); #1;
    cyc++;
    wren = w;
    for (int i = 0; i < N; i++) begin
      wraddr[i*AW +: AW] = AW'(cyc * 4 + i);
      wrdata[i*DW +: DW] = DW'(32'hD000_0000 + 32'(cyc * 16 + i));
    end
    if (fix2) begin
      wraddr[2*AW +: AW] = 8'h10;
      wrdata[2*DW +: DW] = 32'h0000_00A5;
    end
    @(negedge aclk);
    r_rdy = wrrdy; r_w = mem_wren; r_sel = mem_wrsel; r_a = mem_wraddr; r_d = mem_wrdata;
  endtask

  task automatic do_reset(input logic [N-1:0] w_after);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    chk("async_rst_mem_wren", 64'(mem_wren), 64'(0));
    chk("async_rst_wrrdy", 64'(wrrdy), 64'(0));
    @(posedge aclk); #1;
    wren    = w_after;
    aresetn = 1'b1;
    @(negedge aclk);
    r_rdy = wrrdy; r_w = mem_wren; r_sel = mem_wrsel; r_a = mem_wraddr; r_d = mem_wrdata;
  endtask

  logic [N-1:0] mix_tbl [12] = '{4'b0110, 4'b0110, 4'b0000, 4'b1001, 4'b1111, 4'b0100,
                                 4'b0000, 4'b0011, 4'b1000, 4'b1010, 4'b0001, 4'b0000};

  initial begin
    @(negedge aclk);
    chk("init_mem_wren", 64'(mem_wren), 64'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // single agent, zero-cycle accept and latency-1 presentation
    do_reset('0);
    fix2 = 1'b1;
    step(4'b0100);
    fix2 = 1'b0;
    chk("a2_wrrdy_same_cycle", 64'(r_rdy), 64'(4'b0100));
    step(4'b0000);
    chk("a2_mem_wren", 64'(r_w), 64'(1));
    chk("a2_mem_wraddr", 64'(r_a), 64'(8'h10));
    chk("a2_mem_wrdata", 64'(r_d), 64'(32'hA5));
    chk("a2_mem_wrsel", 64'(r_sel), 64'(2));
    step(4'b0000);
    chk("idle_mem_wren", 64'(r_w), 64'(0));
    chk("idle_wrrdy", 64'(r_rdy), 64'(0));

    // all four agents requesting continuously
    do_reset('0);
    for (int k = 0; k < 21; k++) begin
      step(4'b1111);
      if (k > 0) begin
        chk("rr4_mem_wren", 64'(r_w), 64'(1));
        chk("rr4_mem_wrsel", 64'(r_sel),
            64'(BURST ? ((k - 1) / MAXB) % N : (k - 1) % N));
      end
    end

    // lone requester through burst limit: regrant without bubble
    do_reset('0);
    for (int k = 0; k < 10; k++) begin
      step(4'b0001);
      chk("solo_wrrdy", 64'(r_rdy), 64'(4'b0001));
      if (k > 0) chk("solo_mem_wren", 64'(r_w), 64'(1));
    end

    // owner drops while another agent waits
    do_reset('0);
    step(4'b1000);
    chk("drop_first", 64'(r_rdy), 64'(4'b1000));
    step(4'b1010);
`ifdef WRAGENT_ARBITER_BURST_EN
    chk("drop_hold_beat2", 64'(r_rdy), 64'(4'b1000));
`else
    chk("drop_rr_beat2", 64'(r_rdy), 64'(4'b0010));
`endif
    step(4'b0010);
    chk("drop_handover", 64'(r_rdy), 64'(4'b0010));
`ifdef WRAGENT_ARBITER_BURST_EN
    chk("drop_prev_sel", 64'(r_sel), 64'(3));
`endif
    step(4'b0000);
    chk("drop_no_bubble_wren", 64'(r_w), 64'(1));
    chk("drop_no_bubble_sel", 64'(r_sel), 64'(1));

    // agents 0 and 2 continuously
    do_reset('0);
    for (int k = 0; k < 9; k++) begin
      step(4'b0101);
      if (k > 0)
        chk("alt02_mem_wrsel", 64'(r_sel),
            64'(BURST ? (((k - 1) / MAXB) % 2) * 2 : ((k - 1) % 2) * 2));
    end

    // idle cycles keep the pointer
    do_reset('0);
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);
    step(4'b1001);
    chk("idle_keeps_ptr", 64'(r_rdy), 64'(4'b1000));

    // reset mid-stream, then arbitration restarts at agent 0
    do_reset('0);
    repeat (3) step(4'b0010);
    do_reset(4'b0011);
    chk("post_rst_first_grant", 64'(r_rdy), 64'(4'b0001));
    step(4'b0000);
    chk("post_rst_mem_wrsel", 64'(r_sel), 64'(0));

    // mixed directed vectors against the model
    do_reset('0);
    for (int k = 0; k < 12; k++) step(mix_tbl[k]);

    repeat (2) step(4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wragent_arbiter.md
WRAGENT_ARBITER -- requirements
Module: wragent_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 SHALL have parameter NB_WRAGENT, default 4, number of write agents (1..16).
REQ-004 SHALL have parameter SELECT_WIDTH, default (NB_WRAGENT==1 ? 1 : clog2(NB_WRAGENT)), agent index width.
REQ-005 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one agent (1..16).
REQ-006 aclk  in  1  sole clock; all state on rising edge.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 wren  in  NB_WRAGENT  per-agent write request (valid).
REQ-009 wraddr  in  NB_WRAGENT*ADDR_WIDTH  per-agent address, agent i at slice i.
REQ-010 wrdata  in  NB_WRAGENT*DATA_WIDTH  per-agent data, agent i at slice i.
REQ-011 wrrdy  out  NB_WRAGENT  per-agent accept; beat transfers when wren[i] and wrrdy[i] are both 1.
REQ-012 mem_wren  out  1  registered write strobe to the shared RAM write port.
REQ-013 mem_wraddr  out  ADDR_WIDTH  registered write address.
REQ-014 mem_wrdata  out  DATA_WIDTH  registered write data.
REQ-015 mem_wrsel  out  SELECT_WIDTH  registered index of the agent owning the beat (feeds per-row write accounting).

Function
REQ-016 SHALL assert at most one wrrdy bit per cycle, and only for an agent with wren high.
REQ-017 wrrdy SHALL be combinational from current wren and registered arbiter state (zero-cycle accept).
REQ-018 An accepted beat SHALL appear on mem_wren/mem_wraddr/mem_wrdata/mem_wrsel on the next rising edge (latency 1); mem_wren SHALL be 0 in cycles following no accept.
REQ-019 Agents SHALL hold wren, wraddr, wrdata stable until accepted; the block SHALL NOT rely on this for correctness of other agents.
REQ-020 Round-robin: registered pointer PTR; search starts at PTR, ascends, wraps NB_WRAGENT-1 -> 0; first requesting agent wins.
REQ-021 After a grant to agent g that releases the port, PTR SHALL become (g+1) mod NB_WRAGENT.
REQ-022 FSM states: IDLE (no owner, arbitrate each cycle) and HOLD (owner g, beat count CNT).
REQ-023 IDLE -> HOLD on a grant when burst mode is active and MAX_BURST>1; CNT=1.
REQ-024 In HOLD: wren[g]=1 and CNT<MAX_BURST -> grant g, CNT+1; CNT==MAX_BURST or wren[g]=0 -> PTR=g+1, return to IDLE and arbitrate others in the same cycle (no bubble).
REQ-025 HOLD reaching MAX_BURST with only g requesting SHALL regrant g via IDLE arbitration in the same cycle (no bubble).
REQ-026 NB_WRAGENT==1 SHALL grant agent 0 whenever wren[0]=1; mem_wrsel=0.
REQ-027 No requests SHALL leave PTR unchanged and all wrrdy=0.

Reset
REQ-028 aresetn low SHALL asynchronously force mem_wren=0, mem_wraddr=0, mem_wrdata=0, mem_wrsel=0, PTR=0, CNT=0, state IDLE.
REQ-029 wrrdy SHALL be 0 while aresetn is low; a beat registered but not yet presented at reset assertion SHALL be discarded.
REQ-030 First arbitration after reset release SHALL start at agent 0.

Configuration
REQ-031 Macro WRAGENT_ARBITER_BURST_EN: defined -> HOLD state and MAX_BURST behaviour per REQ-023..025.
REQ-032 Undefined -> FSM stays in IDLE, PTR advances after every grant (pure one-beat round-robin), MAX_BURST ignored.

Verification (NB_WRAGENT=4, MAX_BURST=4, BURST_EN defined unless stated)
REQ-033 Reset mid-stream: agent 1 streaming, aresetn low one cycle -> mem_wren=0 immediately; after release, agents 0,1 requesting -> agent 0 granted first.
REQ-034 All 4 agents requesting continuously -> mem_wrsel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., mem_wren=1 every cycle.
REQ-035 Agent 2 alone, addr 0x10 data 0xA5 -> wrrdy[2]=1 same cycle; next cycle mem_wren=1, mem_wraddr=0x10, mem_wrdata=0xA5, mem_wrsel=2.
REQ-036 Agent 3 holding, drops wren after 2 beats while agent 1 requests -> agent 1 granted in the cycle agent 3 drops, no idle cycle.
REQ-037 BURST_EN undefined, agents 0 and 2 requesting continuously -> mem_wrsel alternates 0,2,0,2.
